// File: rtl/fp_result_logger_if.sv
// Snoop and character-stream bundle for fp_result_logger.
// The slave view belongs to the logger; the master view belongs to whatever
// drives the snooped FPU request/response and sinks the ASCII stream.
interface fp_result_logger_if;
    logic [63:0] exe_data1;
    logic [63:0] exe_data2;
    logic        exe_enable;
    logic [63:0] exe_result;
    logic [4:0]  exe_flags;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        overflow;
    logic [15:0] drop_count;
    logic        busy;

    modport master (
        output exe_data1, exe_data2, exe_enable, exe_result, exe_flags, tx_ready,
        input  tx_data, tx_valid, overflow, drop_count, busy
    );

    modport slave (
        input  exe_data1, exe_data2, exe_enable, exe_result, exe_flags, tx_ready,
        output tx_data, tx_valid, overflow, drop_count, busy
    );
endinterface

// File: rtl/fp_result_logger.sv
// fp_result_logger: pairs each enabled FPU request with the response one cycle
// later, buffers the records and prints each as "data1 data2 result flags\n"
// in lowercase hex on a byte-wide valid/ready stream.
module fp_result_logger #(
    parameter int unsigned DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    fp_result_logger_if.slave  bus
);
    localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;
    localparam logic [5:0]  LAST_K = 6'd53;

    typedef struct packed {
        logic [63:0] data1;
        logic [63:0] data2;
        logic [63:0] result;
        logic [4:0]  flags;
    } rec_t;

    typedef enum logic {IDLE, EMIT} state_t;

    logic          pend_q;
    logic [63:0]   pd1_q, pd2_q;
    rec_t          mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic [15:0]   drop_q;
    state_t        state_q, state_d;
    logic [5:0]    k_q, k_d;
    rec_t          hold_q, hold_d;

    rec_t          push_rec, rd_rec;
    logic          push, pop, push_ok, drop, fifo_full, fifo_empty, hs;
    logic [63:0]   field;
    logic [5:0]    off;
    logic [7:0]    sel;
    logic [3:0]    nib;
    logic          is_hex;
    logic [7:0]    ch;

    assign push       = pend_q;
    assign push_rec   = {pd1_q, pd2_q, bus.exe_result, bus.exe_flags};
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push_ok    = push && (!fifo_full || pop);
    assign drop       = push && !push_ok;
    assign rd_rec     = mem_q[rptr_q];
    assign hs         = (state_q == EMIT) && bus.tx_ready;

    // Capture the request operands; they pair with the response on the next edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_q <= 1'b0;
            pd1_q  <= '0;
            pd2_q  <= '0;
        end else begin
            pend_q <= bus.exe_enable;
            if (bus.exe_enable) begin
                pd1_q <= bus.exe_data1;
                pd2_q <= bus.exe_data2;
            end
        end
    end

    // Record storage; contents are only meaningful where count says so
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wptr_q] <= push_rec;
    end

    // FIFO pointers, occupancy and sticky drop accounting
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) drop_q <= drop_q + 1'b1;
            end
        end
    end

    // Serializer state, character index and holding register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            hold_q  <= hold_d;
        end
    end

    // Serializer next state; reload straight from the FIFO after the newline
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        hold_d  = hold_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    hold_d  = rd_rec;
                    k_d     = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (hs) begin
                    if (k_q != LAST_K) begin
                        k_d = k_q + 1'b1;
                    end else if (!fifo_empty) begin
                        pop    = 1'b1;
                        hold_d = rd_rec;
                        k_d    = '0;
                    end else begin
                        k_d     = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Character map: pick field and nibble offset (MSB first) for index k
    always_comb begin
        field  = '0;
        off    = '0;
        is_hex = 1'b0;
        ch     = 8'h00;
        if (k_q < 6'd16) begin
            field = hold_q.data1;  off = 6'd15 - k_q; is_hex = 1'b1;
        end else if (k_q == 6'd16 || k_q == 6'd33 || k_q == 6'd50) begin
            ch = 8'h20;
        end else if (k_q <= 6'd32) begin
            field = hold_q.data2;  off = 6'd32 - k_q; is_hex = 1'b1;
        end else if (k_q <= 6'd49) begin
            field = hold_q.result; off = 6'd49 - k_q; is_hex = 1'b1;
        end else if (k_q <= 6'd52) begin
            field = {59'd0, hold_q.flags}; off = 6'd52 - k_q; is_hex = 1'b1;
        end else begin
            ch = 8'h0A;
        end
        sel = {off, 2'b00};
        nib = field[sel +: 4];
        if (is_hex) ch = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
    end

    // Stream and status outputs
    always_comb begin
        bus.tx_valid   = (state_q == EMIT);
        bus.tx_data    = (state_q == EMIT) ? ch : 8'h00;
        bus.overflow   = overflow_q;
        bus.drop_count = drop_q;
        bus.busy       = !fifo_empty || (state_q == EMIT) || pend_q;
    end
endmodule

// File: tb/tb_fp_result_logger.sv
// Bench for fp_result_logger: table vectors, random traffic with backpressure
// against a formatted-string reference, and hand sequences for burst overflow,
// full-FIFO push with pop, reset mid-line and idle snooping.
module tb_fp_result_logger;
    localparam int unsigned DEPTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;

    fp_result_logger_if bus();

    fp_result_logger #(.DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] res;
        logic [4:0]  fl;
    } rec_t;

    typedef struct {
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] res;
        logic [4:0]  fl;
        string       line;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    rec_t        rec_q[$];
    logic [7:0]  got_q[$];
    logic        prev_en = 1'b0;
    logic [63:0] prev_d1 = '0;
    logic [63:0] prev_d2 = '0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;
    vec_t        tv[4];

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // advance one cycle; a character counts when valid&ready precede the edge
    task automatic step();
        if (reset) begin
            if (prev_stall) begin
                check("hold_valid", {63'd0, bus.tx_valid}, 64'd1);
                check("hold_data", {56'd0, bus.tx_data}, {56'd0, prev_data});
            end
            if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_data  = bus.tx_data;
        end else begin
            prev_stall = 1'b0;
        end
        @(negedge clock);
    endtask

    // set snoop inputs; the response driven now completes last cycle's request
    task automatic drive(logic en, logic [63:0] d1, logic [63:0] d2,
                         logic [63:0] res, logic [4:0] fl);
        bus.exe_enable = en;
        bus.exe_data1  = d1;
        bus.exe_data2  = d2;
        bus.exe_result = res;
        bus.exe_flags  = fl;
        if (prev_en && reset) rec_q.push_back('{prev_d1, prev_d2, res, fl});
        prev_en = en && reset;
        prev_d1 = d1;
        prev_d2 = d2;
    endtask

    function automatic logic [63:0] r64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic string fmt(rec_t r);
        logic [7:0] f8;
        f8 = {3'b000, r.fl};
        return $sformatf("%016h %016h %016h %02h\n", r.d1, r.d2, r.res, f8);
    endfunction

    function automatic string lines_of(rec_t r[$]);
        string s;
        s = "";
        foreach (r[i]) s = {s, fmt(r[i])};
        return s;
    endfunction

    // one comparison per expected line, at its first differing character
    task automatic compare_lines(string name, string s);
        int nl;
        int p;
        logic [7:0] g;
        logic [7:0] e;
        nl = s.len() / 54;
        check({name, "_len"}, 64'(got_q.size()), 64'(s.len()));
        for (int l = 0; l < nl; l++) begin
            p = l * 54 + 53;
            for (int j = l * 54; j < l * 54 + 54; j++) begin
                if (j >= got_q.size() || got_q[j] != s[j]) begin
                    p = j;
                    break;
                end
            end
            g = (p < got_q.size()) ? got_q[p] : 8'hxx;
            e = s[p];
            check($sformatf("%s_line%0d_char%0d", name, l, p % 54), {56'd0, g}, {56'd0, e});
        end
    endtask

    task automatic wait_idle(string name, int bound, bit rnd);
        int n;
        n = 0;
        while ((bus.busy || bus.tx_valid) && n < bound) begin
            if (rnd) bus.tx_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        checks++;
        if (n >= bound) begin
            errors++;
            $display("FAIL %s_timeout: busy=%0b after %0d cycles, required 0", name, bus.busy, n);
        end
        bus.tx_ready = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        got_q.delete();
        rec_q.delete();
        prev_en    = 1'b0;
        prev_stall = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int   ops;
        int   gaps;
        int   n;
        int   active;
        logic en;

        tv[0] = '{64'h000000003F800000, 64'h0000000040000000, 64'h0000000000000001, 5'h01,
                  "000000003f800000 0000000040000000 0000000000000001 01\n"};
        tv[1] = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 64'h0123456789ABCDEF, 5'h1F,
                  "ffffffffffffffff 0000000000000000 0123456789abcdef 1f\n"};
        tv[2] = '{64'hDEADBEEFCAFEF00D, 64'h8000000000000000, 64'h7FF8000000000000, 5'h10,
                  "deadbeefcafef00d 8000000000000000 7ff8000000000000 10\n"};
        tv[3] = '{64'h3FF0000000000000, 64'hBFF0000000000000, 64'h0000000000000000, 5'h00,
                  "3ff0000000000000 bff0000000000000 0000000000000000 00\n"};

        // reset state, with an enable that must be ignored
        bus.tx_ready = 1'b1;
        drive(1'b1, 64'h1111, 64'h2222, 64'h3333, 5'h07);
        repeat (3) @(negedge clock);
        check("rst_tx_valid", {63'd0, bus.tx_valid}, 64'd0);
        check("rst_tx_data", {56'd0, bus.tx_data}, 64'd0);
        check("rst_overflow", {63'd0, bus.overflow}, 64'd0);
        check("rst_drop_count", {48'd0, bus.drop_count}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        drive(1'b0, '0, '0, '0, '0);
        reset = 1'b1;
        repeat (5) step();
        check("rst_en_ignored_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_en_ignored_out", 64'(got_q.size()), 64'd0);

        // table vectors with ready high, including first-character latency
        foreach (tv[i]) begin
            got_q.delete();
            rec_q.delete();
            drive(1'b1, tv[i].d1, tv[i].d2, r64(), 5'($urandom()));
            step();
            drive(1'b0, r64(), r64(), tv[i].res, tv[i].fl);
            check($sformatf("vec%0d_lat_e0", i), {63'd0, bus.tx_valid}, 64'd0);
            step();
            check($sformatf("vec%0d_lat_e1", i), {63'd0, bus.tx_valid}, 64'd0);
            check($sformatf("vec%0d_busy_e1", i), {63'd0, bus.busy}, 64'd1);
            step();
            check($sformatf("vec%0d_lat_e2", i), {63'd0, bus.tx_valid}, 64'd1);
            check($sformatf("vec%0d_k0", i), {56'd0, bus.tx_data}, {56'd0, 8'(tv[i].line[0])});
            wait_idle($sformatf("vec%0d", i), 200, 1'b0);
            compare_lines($sformatf("vec%0d", i), tv[i].line);
        end

        // backpressure on the reference op
        got_q.delete();
        rec_q.delete();
        drive(1'b1, tv[0].d1, tv[0].d2, r64(), 5'h00);
        step();
        drive(1'b0, r64(), r64(), tv[0].res, tv[0].fl);
        step();
        wait_idle("bp", 2000, 1'b1);
        compare_lines("bp", tv[0].line);

        // random traffic, never more than FIFO plus holding register outstanding
        got_q.delete();
        rec_q.delete();
        ops = 0;
        for (int c = 0; c < 300; c++) begin
            bus.tx_ready = 1'($urandom_range(0, 1));
            en = (ops < int'(DEPTH) + 1) && ($urandom_range(0, 11) == 0);
            if (en) ops++;
            drive(en, r64(), r64(), r64(), 5'($urandom()));
            step();
        end
        drive(1'b0, r64(), r64(), r64(), 5'($urandom()));
        step();
        wait_idle("rand", 6000, 1'b1);
        compare_lines("rand", lines_of(rec_q));
        check("rand_overflow", {63'd0, bus.overflow}, 64'd0);
        check("rand_drop_count", {48'd0, bus.drop_count}, 64'd0);

        // burst of 12 back-to-back ops into an 8-deep FIFO
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 64'h1000 + 64'(i), 64'h2000 + 64'(i), r64(), 5'($urandom()));
            step();
        end
        drive(1'b0, r64(), r64(), r64(), 5'($urandom()));
        gaps = 0;
        n = 0;
        while ((bus.busy || bus.tx_valid) && n < 1000) begin
            if (!bus.tx_valid && got_q.size() > 0 && got_q.size() < 9 * 54) gaps++;
            step();
            n++;
        end
        check("burst_timeout", 64'(n < 1000), 64'd1);
        check("burst_gaps", 64'(gaps), 64'd0);
        check("burst_drop_count", {48'd0, bus.drop_count}, 64'd3);
        check("burst_overflow", {63'd0, bus.overflow}, 64'd1);
        compare_lines("burst", lines_of(rec_q[0:8]));

        // full FIFO: push lands on the same edge as the newline pop
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, r64(), r64(), r64(), 5'($urandom()));
            step();
        end
        drive(1'b0, r64(), r64(), r64(), 5'($urandom()));
        n = 0;
        while (!(bus.tx_valid && bus.tx_data == 8'h0A) && n < 200) begin
            step();
            n++;
        end
        check("full_newline_seen", 64'(n < 200), 64'd1);
        bus.tx_ready = 1'b0;
        drive(1'b1, r64(), r64(), r64(), 5'($urandom()));
        step();
        bus.tx_ready = 1'b1;
        drive(1'b0, r64(), r64(), r64(), 5'($urandom()));
        step();
        check("full_pop_drop_count", {48'd0, bus.drop_count}, 64'd0);
        check("full_pop_overflow", {63'd0, bus.overflow}, 64'd0);
        wait_idle("full_pop", 1000, 1'b0);
        check("full_pop_records", 64'(rec_q.size()), 64'd10);
        compare_lines("full_pop", lines_of(rec_q));

        // reset while k=20 is on the stream
        got_q.delete();
        rec_q.delete();
        drive(1'b1, tv[1].d1, tv[1].d2, r64(), 5'h00);
        step();
        drive(1'b0, r64(), r64(), tv[1].res, tv[1].fl);
        n = 0;
        while (got_q.size() < 20 && n < 100) begin
            step();
            n++;
        end
        check("midreset_k20_reached", 64'(got_q.size()), 64'd20);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_tx_valid", {63'd0, bus.tx_valid}, 64'd0);
        check("midreset_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clock);
        do_reset();
        repeat (5) step();
        check("midreset_no_resume", 64'(got_q.size()), 64'd0);
        check("midreset_busy_after", {63'd0, bus.busy}, 64'd0);
        drive(1'b1, tv[2].d1, tv[2].d2, r64(), 5'h00);
        step();
        drive(1'b0, r64(), r64(), tv[2].res, tv[2].fl);
        step();
        wait_idle("midreset_fresh", 200, 1'b0);
        compare_lines("midreset_fresh", tv[2].line);

        // enable low with changing data: nothing happens
        got_q.delete();
        active = 0;
        for (int c = 0; c < 100; c++) begin
            bus.tx_ready = 1'($urandom_range(0, 1));
            drive(1'b0, r64(), r64(), r64(), 5'($urandom()));
            step();
            if (bus.busy || bus.tx_valid) active++;
        end
        check("idle_active_cycles", 64'(active), 64'd0);
        check("idle_no_output", 64'(got_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
